// File: rtl/alu_req_driver.sv
// alu_req_driver
//   Initiator side of the ALU operand/result interface. Operation requests
//   arrive over a valid/ready port and wait in a small circular FIFO. One
//   request at a time is issued to the combinational ALU. The result is
//   captured one cycle later and returned, in request order, over a
//   valid/ready response port.
//
// Parameters
//   DEPTH   request FIFO entries (power of two, >= 2)
//   CTRL_W  ALU control width
//   DATA_W  operand / result width
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   req_valid/req_ready          request handshake (req_ready = !full)
//   req_ctrl, req_a, req_b       request payload
//   alu_ctrl, alu_a, alu_b       issue registers driving the ALU inputs
//   alu_result                   combinational ALU output
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_ctrl         captured result and the ctrl that produced it
//   busy                         FIFO non-empty or FSM not IDLE
//   op_count                     completed-response counter (optional)
//
// Build option
//   ALU_REQ_DRIVER_OPCOUNT_EN    adds the op_count output and its counter
module alu_req_driver #(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CTRL_W-1:0] req_ctrl,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [CTRL_W-1:0] rsp_ctrl,
    output logic              busy
`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
    ,
    output logic [31:0]       op_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty, fifo_full;
    logic             push, pop, capture;
    state_t           state, state_nxt;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    // Ready depends on occupancy only, so a pop in the same cycle never
    // opens a slot for a push while full.
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;

    // ---------------- request FIFO ----------------
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{ctrl: req_ctrl, a: req_a, b: req_b};
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:    pop     = !fifo_empty;
            ISSUE:   capture = 1'b1;
            HOLD:    pop     = rsp_ready && !fifo_empty;
            default: ;
        endcase
    end

    // Response is valid exactly while holding a captured result.
    assign rsp_valid = (state == HOLD);
    assign busy      = !fifo_empty || (state != IDLE);

    // ---------------- issue / capture registers ----------------
    // The alu_* registers only move on a pop, so the ALU inputs are stable
    // for the whole ISSUE cycle and keep the last op in IDLE/HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_ctrl   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_ctrl   <= '0;
        end else begin
            if (pop) begin
                alu_ctrl <= mem[rd_ptr].ctrl;
                alu_a    <= mem[rd_ptr].a;
                alu_b    <= mem[rd_ptr].b;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_ctrl   <= alu_ctrl;
            end
        end
    end

`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
    logic [31:0] op_count_q;

    // Counts completed responses; wraps silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                      op_count_q <= '0;
        else if (rsp_valid && rsp_ready) op_count_q <= op_count_q + 32'd1;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
module tb_alu_req_driver;

    localparam int DEPTH  = 4;
    localparam int CTRL_W = 6;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [CTRL_W-1:0] req_ctrl = '0;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_result;
    logic [CTRL_W-1:0] rsp_ctrl;
    logic              busy;
`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
    logic [31:0]       op_count;
`endif

    alu_req_driver #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ctrl(rsp_ctrl),
        .busy(busy)
`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clock = ~clock;

    // Stub ALU
    assign alu_result = alu_a + alu_b + DATA_W'(alu_ctrl);

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] res;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] rsp_log[$];
    int                vectors = 0;
    int                miscompares = 0;
    int                rsp_seen = 0;
    bit                toggle_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected results enter when a request is accepted and are
    // compared when the matching response handshake happens. Sampling on the
    // falling edge sees the values the next rising edge will act on.
    always @(negedge clock) begin
        if (reset) begin
            if (req_valid && req_ready)
                sb.push_back('{ctrl: req_ctrl, res: req_a + req_b + DATA_W'(req_ctrl)});
            if (rsp_valid && rsp_ready) begin
                exp_t e;
                rsp_seen++;
                rsp_log.push_back(rsp_result);
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_result);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_ctrl", 64'(rsp_ctrl), 64'(e.ctrl));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (toggle_en) rsp_ready = ~rsp_ready;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b);
        bit ok = 1'b0;
        req_ctrl  = c;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            sample();
            ok = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!ok) chk("push_timeout", 64'(ok), 64'(1));
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            sample();
            if (sb.size() == 0 && !rsp_valid && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({"drain_", tag}, 64'(ok), 64'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit got;

        // ---------------- reset state ----------------
        #2 reset = 1'b0;
        sample();
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_alu", 64'({alu_ctrl, alu_a}), 64'(0));
        chk("rst_alu_b", 64'(alu_b), 64'(0));
        chk("rst_rsp", 64'({rsp_ctrl, rsp_result}), 64'(0));

        // ---------------- single op ----------------
        tick();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_ctrl  = 6'h01;
        req_a     = 32'h0000_0010;
        req_b     = 32'h0000_0020;
        req_valid = 1'b1;
        sample();
        chk("t1_ready", 64'(req_ready), 64'(1));
        tick();                     // edge N: accepted
        req_valid = 1'b0;
        sample();
        chk("t1_busy_n", 64'(busy), 64'(1));
        chk("t1_valid_n", 64'(rsp_valid), 64'(0));
        tick();                     // edge N+1: popped
        sample();
        chk("t1_valid_n1", 64'(rsp_valid), 64'(0));
        chk("t1_alu_a", 64'(alu_a), 64'(32'h10));
        chk("t1_alu_b", 64'(alu_b), 64'(32'h20));
        chk("t1_alu_ctrl", 64'(alu_ctrl), 64'(6'h01));
        tick();                     // edge N+2: response valid
        sample();
        chk("t1_valid_n2", 64'(rsp_valid), 64'(1));
        chk("t1_result", 64'(rsp_result), 64'(32'h0000_0031));
        chk("t1_ctrl", 64'(rsp_ctrl), 64'(6'h01));
        tick();                     // edge N+3: response handshake
        sample();
        chk("t1_busy_after", 64'(busy), 64'(0));
        chk("t1_valid_after", 64'(rsp_valid), 64'(0));
        chk("t1_rsp_count", 64'(rsp_seen), 64'(1));

        // ---------------- fill / full ----------------
        tick();
        rsp_ready = 1'b0;
        base = rsp_seen;
        for (int i = 0; i < 5; i++)
            push(CTRL_W'(i + 8), DATA_W'(100 * i), DATA_W'(7));
        req_ctrl  = 6'h0D;
        req_a     = 32'h0000_0500;
        req_b     = 32'h0000_0007;
        req_valid = 1'b1;
        sample();
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_accepted", 64'(sb.size()), 64'(5));
        chk("full_hold_valid", 64'(rsp_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            sample();
            chk($sformatf("full_ready_hold%0d", k), 64'(req_ready), 64'(0));
        end
        tick();
        rsp_ready = 1'b1;
        push(6'h0D, 32'h0000_0500, 32'h0000_0007);
        drain("full");
        chk("full_rsp_count", 64'(rsp_seen - base), 64'(6));
        chk("full_ready_back", 64'(req_ready), 64'(1));

        // ---------------- backpressure hold ----------------
        tick();
        rsp_ready = 1'b0;
        push(6'h03, 32'h0000_1234, 32'h0000_1111);
        push(6'h04, 32'h0000_0005, 32'h0000_0006);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_got_valid", 64'(got), 64'(1));
        for (int h = 0; h < 5; h++) begin
            chk($sformatf("bp_valid%0d", h), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp_result%0d", h), 64'(rsp_result), 64'(32'h0000_2348));
            chk($sformatf("bp_ctrl%0d", h), 64'(rsp_ctrl), 64'(6'h03));
            chk($sformatf("bp_alu%0d", h), 64'({alu_ctrl, alu_a}), 64'({6'h03, 32'h0000_1234}));
            tick();
            sample();
        end
        tick();
        rsp_ready = 1'b1;
        base = rsp_seen;
        sample();
        tick();                     // release: one handshake, next op popped
        rsp_ready = 1'b0;
        sample();
        chk("bp_valid_drop", 64'(rsp_valid), 64'(0));
        chk("bp_next_alu", 64'({alu_ctrl, alu_a}), 64'({6'h04, 32'h0000_0005}));
        tick();
        sample();
        chk("bp_next_valid", 64'(rsp_valid), 64'(1));
        chk("bp_next_result", 64'(rsp_result), 64'(32'h0000_000F));
        chk("bp_single_rsp", 64'(rsp_seen - base), 64'(1));
        tick();
        rsp_ready = 1'b1;
        drain("bp");

        // ---------------- wrap-around ----------------
        tick();
        rsp_ready = 1'b1;
        toggle_en = 1'b1;
        rsp_log.delete();
        for (int i = 0; i < 10; i++)
            push(6'h00, DATA_W'(i), 32'hFFFF_FFFF);
        toggle_en = 1'b0;
        rsp_ready = 1'b1;
        drain("wrap");
        chk("wrap_count", 64'(rsp_log.size()), 64'(10));
        for (int k = 0; k < 10; k++) begin
            logic [DATA_W-1:0] e;
            e = DATA_W'(k) - 32'd1;
            if (k < rsp_log.size())
                chk($sformatf("wrap_%0d", k), 64'(rsp_log[k]), 64'(e));
        end

        // ---------------- reset mid-operation ----------------
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(CTRL_W'(i + 16), DATA_W'(3 * i), DATA_W'(32'h40));
        rsp_ready = 1'b1;
        tick();                     // op0 consumed, op1 now in ISSUE, 3 queued
        rsp_ready = 1'b0;
        chk("mid_busy_before", 64'(busy), 64'(1));
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_req_ready", 64'(req_ready), 64'(1));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_rsp_result", 64'(rsp_result), 64'(0));
        chk("mid_alu_a", 64'(alu_a), 64'(0));
`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
        chk("opc_reset", 64'(op_count), 64'(0));
`endif
        base = rsp_seen;
        tick();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        sample();
        chk("mid_no_stale", 64'(rsp_seen - base), 64'(0));
        chk("mid_idle", 64'(busy), 64'(0));
        tick();
        push(6'h2A, 32'hDEAD_0000, 32'h0000_BEEF);
        drain("recover");
        chk("mid_recover_rsp", 64'(rsp_seen - base), 64'(1));

`ifdef ALU_REQ_DRIVER_OPCOUNT_EN
        // ---------------- op counter ----------------
        tick();
        for (int i = 0; i < 6; i++)
            push(CTRL_W'(i), DATA_W'(i), DATA_W'(i));
        drain("opc");
        chk("opc_seven", 64'(op_count), 64'(7));
        tick();
        force dut.op_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.op_count_q;
        chk("opc_forced", 64'(op_count), 64'(32'hFFFF_FFFF));
        tick();
        push(6'h01, 32'h1, 32'h1);
        drain("opc_wrap");
        chk("opc_wrap", 64'(op_count), 64'(0));
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
